// File: rtl/tmds_tx_core.sv
// TMDS transmitter core: three DVI 8b/10b channel encoders, a constant clock-channel word,
// and optional HDMI video preamble / guard band insertion driven by a de look-ahead line.

module tmds_enc #(
   parameter logic [9:0] GUARD_WORD = 10'b1011001100
) (
   input  logic       pclk,
   input  logic       rst_n,
   input  logic [7:0] d_i,
   input  logic       de_i,
   input  logic [1:0] c_i,
   input  logic       guard_i,
   output logic [9:0] dout_o
);

   logic [8:0]        q_m_d, q_m_q;
   logic              de_q;
   logic [1:0]        c_q;
   logic              guard_q;
   logic [3:0]        n1_d, n1_q;
   logic              use_xnor;
   logic [9:0]        dout_d, dout_q;
   logic signed [4:0] cnt_d, cnt_q;
   logic signed [4:0] diff, two_q8, two_nq8;

   // Stage 1: transition-minimising q_m.
   always_comb begin
      n1_d = '0;
      for (int i = 0; i < 8; i++) n1_d = n1_d + 4'(d_i[i]);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d_i[0]);
      q_m_d    = '0;
      q_m_d[0] = d_i[0];
      for (int i = 1; i < 8; i++)
         q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ d_i[i]) : (q_m_d[i-1] ^ d_i[i]);
      q_m_d[8] = ~use_xnor;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         q_m_q   <= '0;
         de_q    <= 1'b0;
         c_q     <= 2'b00;
         guard_q <= 1'b0;
      end else begin
         q_m_q   <= q_m_d;
         de_q    <= de_i;
         c_q     <= c_i;
         guard_q <= guard_i;
      end
   end

   // Stage 2: DC balancing; cnt tracks the running ones-minus-zeros of emitted words.
   always_comb begin
      n1_q = '0;
      for (int i = 0; i < 8; i++) n1_q = n1_q + 4'(q_m_q[i]);
      diff    = $signed({n1_q, 1'b0} - 5'd8);
      two_q8  = $signed({3'b000, q_m_q[8], 1'b0});
      two_nq8 = $signed({3'b000, ~q_m_q[8], 1'b0});
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      if (!de_q) begin
         cnt_d = '0;
         if (guard_q) dout_d = GUARD_WORD;
         else begin
            case (c_q)
               2'b00:   dout_d = 10'b1101010100;
               2'b01:   dout_d = 10'b0010101011;
               2'b10:   dout_d = 10'b0101010100;
               default: dout_d = 10'b1010101011;
            endcase
         end
      end else if ((cnt_q == 5'sd0) || (n1_q == 4'd4)) begin
         dout_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
         cnt_d  = q_m_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if ((!cnt_q[4] && (n1_q > 4'd4)) || (cnt_q[4] && (n1_q < 4'd4))) begin
         dout_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
         cnt_d  = cnt_q + two_q8 - diff;
      end else begin
         dout_d = {1'b0, q_m_q[8], q_m_q[7:0]};
         cnt_d  = cnt_q - two_nq8 + diff;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
         cnt_q  <= '0;
      end else begin
         dout_q <= dout_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout_o = dout_q;

endmodule

module tmds_tx_core #(
   parameter bit         HDMI_MODE   = 1'b0,
   parameter logic [9:0] CLK_PATTERN = 10'b1111100000,
   parameter int         LOOKAHEAD   = 10
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic [23:0] video_din,
   input  logic        video_hsync,
   input  logic        video_vsync,
   input  logic        video_de,
   output logic [9:0]  tmds_data0,
   output logic [9:0]  tmds_data1,
   output logic [9:0]  tmds_data2,
   output logic [9:0]  tmds_clk,
   output logic        tmds_oen
);

   localparam int D   = HDMI_MODE ? LOOKAHEAD : 0;
   localparam int LAT = 2 + D;
   localparam int OW  = $clog2(LAT + 1);
   localparam logic [2:0][9:0] GUARD_WORDS = {10'b1011001100, 10'b0100110011, 10'b1011001100};

   typedef struct packed {
      logic        de;
      logic        vsync;
      logic        hsync;
      logic [23:0] din;
   } vid_t;

   vid_t            tap;
   logic            guard, preamble;
   logic [2:0][7:0] ch_d;
   logic [2:0][1:0] ch_c;
   logic [2:0][9:0] ch_q;
   logic [OW-1:0]   oen_cnt_d, oen_cnt_q;
   logic            oen_d, oen_q;

   generate
      if (HDMI_MODE) begin : g_hdmi
         vid_t [LOOKAHEAD:1] dl_d, dl_q;
         logic [LOOKAHEAD:0] de_tap;

         always_comb begin
            dl_d[1] = {video_de, video_vsync, video_hsync, video_din};
            for (int k = 2; k <= LOOKAHEAD; k++) dl_d[k] = dl_q[k-1];
            de_tap[0] = video_de;
            for (int k = 1; k <= LOOKAHEAD; k++) de_tap[k] = dl_q[k].de;
         end

         always_ff @(posedge pclk or negedge rst_n) begin
            if (!rst_n) dl_q <= '0;
            else        dl_q <= dl_d;
         end

         // Classification looks ahead from the encoded tap into younger samples.
         assign tap      = dl_q[LOOKAHEAD];
         assign guard    = ~de_tap[LOOKAHEAD] & (de_tap[LOOKAHEAD-1] | de_tap[LOOKAHEAD-2]);
         assign preamble = ~de_tap[LOOKAHEAD] & ~de_tap[LOOKAHEAD-1] & ~de_tap[LOOKAHEAD-2]
                         & (|de_tap[LOOKAHEAD-3:LOOKAHEAD-10]);
      end else begin : g_dvi
         assign tap      = {video_de, video_vsync, video_hsync, video_din};
         assign guard    = 1'b0;
         assign preamble = 1'b0;
      end
   endgenerate

   assign ch_d    = tap.din;
   assign ch_c[0] = {tap.vsync, tap.hsync};
   assign ch_c[1] = {1'b0, preamble};
   assign ch_c[2] = 2'b00;

   for (genvar g = 0; g < 3; g++) begin : g_ch
      tmds_enc #(.GUARD_WORD(GUARD_WORDS[g])) u_enc (
         .pclk    (pclk),
         .rst_n   (rst_n),
         .d_i     (ch_d[g]),
         .de_i    (tap.de),
         .c_i     (ch_c[g]),
         .guard_i (guard),
         .dout_o  (ch_q[g])
      );
   end

   always_comb begin
      oen_cnt_d = oen_cnt_q;
      oen_d     = oen_q;
      if (!oen_q) begin
         if (oen_cnt_q == OW'(LAT - 1)) oen_d = 1'b1;
         else                           oen_cnt_d = oen_cnt_q + OW'(1);
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         oen_cnt_q <= '0;
         oen_q     <= 1'b0;
      end else begin
         oen_cnt_q <= oen_cnt_d;
         oen_q     <= oen_d;
      end
   end

   assign tmds_data0 = ch_q[0];
   assign tmds_data1 = ch_q[1];
   assign tmds_data2 = ch_q[2];
   assign tmds_clk   = CLK_PATTERN;
   assign tmds_oen   = oen_q;

endmodule
